// File: rtl/simon_pkg.sv
// Shared types and constants for the SIMON32/64 decrypt key schedule.
package simon_pkg;

  localparam int ROUNDS = 32;

  typedef logic [15:0] word_t;

  localparam word_t C_CONST = 16'hFFFC;

  // Ascending range so Z0[0] is the first bit of the published z0 sequence.
  localparam logic [0:61] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [1:0] {IDLE, EXPAND, SERVE, HOLD} state_t;

endpackage

// File: rtl/simon_dec_key_sched_if.sv
// Master-key intake and round-key stream between the scheduler and its neighbours.
interface simon_dec_key_sched_if;
  import simon_pkg::*;

  logic        key_valid;
  logic [63:0] key_in;
  logic        key_ready;
  logic        replay;
  word_t       rk_out;
  logic        rk_valid;
  logic        rk_ready;
  logic        rk_last;
  logic        busy;

  modport master (
    output key_valid, key_in, replay, rk_ready,
    input  key_ready, rk_out, rk_valid, rk_last, busy
  );

  modport slave (
    input  key_valid, key_in, replay, rk_ready,
    output key_ready, rk_out, rk_valid, rk_last, busy
  );

endinterface

// File: rtl/simon_key_step.sv
// One step of the SIMON32/64 key recurrence: k[i] from k[i-4], k[i-3], k[i-1] and z0[i-4].
module simon_key_step
  import simon_pkg::*;
(
  input  word_t k_m4,
  input  word_t k_m3,
  input  word_t k_m1,
  input  logic  z,
  output word_t k_new
);

  word_t t;

  assign t = {k_m1[2:0], k_m1[15:3]} ^ k_m3;
  // C_CONST ^ k equals ~k ^ 3, folding the NOT and the round constant together.
  assign k_new = C_CONST ^ k_m4 ^ t ^ {t[0], t[15:1]} ^ {15'd0, z};

endmodule

// File: rtl/simon_dec_key_sched.sv
// Expands a SIMON32/64 master key into 32 round keys and streams them k31 first down to k0.
module simon_dec_key_sched #(
  parameter int ROUNDS    = 32,
  parameter int KEY_WORDS = 4
) (
  input logic                  clk,
  input logic                  rst,
  simon_dec_key_sched_if.slave bus
);
  import simon_pkg::word_t;
  import simon_pkg::state_t;
  import simon_pkg::Z0;
  import simon_pkg::IDLE;
  import simon_pkg::EXPAND;
  import simon_pkg::SERVE;
  import simon_pkg::HOLD;

  localparam int              PW   = $clog2(ROUNDS);
  localparam logic [PW-1:0]   LAST = PW'(ROUNDS - 1);
  localparam logic [PW-1:0]   KW   = PW'(KEY_WORDS);

  state_t        state, state_n;
  logic [PW-1:0] ptr, idx;
  logic [PW-1:0] idx_m4, idx_m3, idx_m1;
  word_t         kreg [ROUNDS];
  word_t         k_new;
  logic          key_take;

  assign key_take = ((state == IDLE) || (state == HOLD)) && bus.key_valid;
  assign idx_m4   = idx - KW;
  assign idx_m3   = idx - PW'(3);
  assign idx_m1   = idx - PW'(1);

  simon_key_step u_step (
    .k_m4  (kreg[idx_m4]),
    .k_m3  (kreg[idx_m3]),
    .k_m1  (kreg[idx_m1]),
    .z     (Z0[idx_m4]),
    .k_new (k_new)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (bus.key_valid) state_n = EXPAND;
      EXPAND: if (idx == LAST) state_n = SERVE;
      SERVE:  if (bus.rk_ready && (ptr == '0)) state_n = HOLD;
      // A new key outranks a replay request arriving in the same cycle.
      HOLD: begin
        if (bus.key_valid)   state_n = EXPAND;
        else if (bus.replay) state_n = SERVE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.key_ready = 1'b0;
    bus.rk_valid  = 1'b0;
    bus.rk_last   = 1'b0;
    bus.busy      = 1'b0;
    bus.rk_out    = '0;
    unique case (state)
      IDLE, HOLD: bus.key_ready = 1'b1;
      EXPAND:     bus.busy = 1'b1;
      SERVE: begin
        bus.busy     = 1'b1;
        bus.rk_valid = 1'b1;
        bus.rk_last  = (ptr == '0);
        bus.rk_out   = kreg[ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      idx <= '0;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          if (bus.key_valid)                     idx <= KW;
          else if ((state == HOLD) && bus.replay) ptr <= LAST;
        end
        EXPAND: begin
          idx <= idx + PW'(1);
          if (idx == LAST) ptr <= LAST;
        end
        SERVE: if (bus.rk_ready && (ptr != '0)) ptr <= ptr - PW'(1);
        default: ;
      endcase
    end
  end

  // Schedule storage carries no reset; only the FSM decides whether it is served.
  always_ff @(posedge clk) begin
    if (!rst && key_take) begin
      for (int w = 0; w < KEY_WORDS; w++) kreg[w] <= bus.key_in[16*w +: 16];
    end else if (!rst && (state == EXPAND)) begin
      kreg[idx] <= k_new;
    end
  end

endmodule
